// File: rtl/riscv_fifo_pkg.sv
// riscv_fifo_pkg: shared sizing helpers and pointer type for the RAM-backed FIFO.
package riscv_fifo_pkg;
    localparam int unsigned FIFO_ABITS = 10;

    typedef struct packed {
        logic                  wrap;
        logic [FIFO_ABITS-1:0] idx;
    } fifo_ptr_t;

    function automatic int unsigned fifo_depth(input int unsigned abits);
        return 1 << abits;
    endfunction

    function automatic int unsigned fifo_cnt_w(input int unsigned abits);
        return abits + 1;
    endfunction
endpackage

// File: rtl/riscv_fifo_outbuf.sv
// riscv_fifo_outbuf: 2-entry head/skid output stage with RAM read-pending tracking.
module riscv_fifo_outbuf #(
    parameter int unsigned DBITS = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [DBITS-1:0] load_data_i,
    input  logic             issue_i,
    input  logic             pop_i,
    output logic [DBITS-1:0] head_o,
    output logic             valid_o,
    output logic             rd_pend_o,
    output logic [1:0]       occ_o
);
    logic [DBITS-1:0] head_q, head_d, skid_q, skid_d, sh_head;
    logic             hv_q, hv_d, sv_q, sv_d, rd_pend_q, rd_pend_d, sh_hv, sh_sv;

    // Pop shifts skid into head first; a load then fills the first free slot.
    always_comb begin
        sh_head   = pop_i ? skid_q : head_q;
        sh_hv     = pop_i ? sv_q : hv_q;
        sh_sv     = pop_i ? 1'b0 : sv_q;
        head_d    = clr_i ? '0 : (load_i && !sh_hv) ? load_data_i : sh_head;
        hv_d      = !clr_i && (sh_hv || load_i);
        skid_d    = (load_i && sh_hv) ? load_data_i : skid_q;
        sv_d      = !clr_i && (sh_sv || (load_i && sh_hv));
        rd_pend_d = !clr_i && issue_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q    <= '0;
            skid_q    <= '0;
            hv_q      <= 1'b0;
            sv_q      <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            skid_q    <= skid_d;
            hv_q      <= hv_d;
            sv_q      <= sv_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    assign head_o    = head_q;
    assign valid_o   = hv_q;
    assign rd_pend_o = rd_pend_q;
    assign occ_o     = {1'b0, hv_q} + {1'b0, sv_q} + {1'b0, rd_pend_q};
endmodule

// File: rtl/riscv_ram_1r1w.sv
// riscv_ram_1r1w: one-write one-read RAM with byte enables and a 1-cycle registered read.
module riscv_ram_1r1w #(
    parameter int unsigned ABITS      = 10,
    parameter int unsigned DBITS      = 32,
    parameter string       TECHNOLOGY = "GENERIC"
) (
    input  logic                     clk_i,
    input  logic [ABITS-1:0]         waddr_i,
    input  logic                     we_i,
    input  logic [(DBITS+7)/8-1:0]   be_i,
    input  logic [DBITS-1:0]         din_i,
    input  logic [ABITS-1:0]         raddr_i,
    input  logic                     re_i,
    output logic [DBITS-1:0]         dout_o
);
    // Generic arrays return old data on a same-address collision; other targets write through.
    localparam bit WR_THROUGH = TECHNOLOGY != "GENERIC";

    logic [DBITS-1:0] mem [2**ABITS];
    logic [DBITS-1:0] dout_q, dout_d, wmask, wdata;

    always_comb begin
        for (int i = 0; i < DBITS; i++) wmask[i] = be_i[i/8];
        wdata  = (din_i & wmask) | (mem[waddr_i] & ~wmask);
        dout_d = !re_i ? dout_q :
                 (WR_THROUGH && we_i && waddr_i == raddr_i) ? wdata : mem[raddr_i];
    end

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata;
        dout_q <= dout_d;
    end

    assign dout_o = dout_q;
endmodule

// File: rtl/riscv_ram_fifo.sv
// riscv_ram_fifo: show-ahead FIFO over riscv_ram_1r1w, hiding read latency behind a 2-entry output stage.
module riscv_ram_fifo
    import riscv_fifo_pkg::*;
#(
    parameter int unsigned ABITS      = FIFO_ABITS,
    parameter int unsigned DBITS      = 32,
    parameter string       TECHNOLOGY = "GENERIC",
    parameter int unsigned AFULL_LVL  = fifo_depth(ABITS) - 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [DBITS-1:0] din_i,
    output logic             full_o,
    output logic             almost_full_o,
    input  logic             pop_i,
    output logic [DBITS-1:0] dout_o,
    output logic             empty_o,
    output logic [ABITS:0]   count_o
);
    localparam int unsigned DEPTH = fifo_depth(ABITS);
    localparam int unsigned CW    = fifo_cnt_w(ABITS);

    fifo_ptr_t        wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ABITS:0]   ram_cnt, count_q, count_d;
    logic             full_q, full_d, afull_q, afull_d;
    logic             push_acc, pop_acc, free, bypass, ram_we, ram_re;
    logic             valid, rd_pend, load;
    logic [1:0]       occ;
    logic [DBITS-1:0] ram_dout, load_data;

    // Bypass only when nothing older exists anywhere, so bypass and RAM data never reorder.
    always_comb begin
        push_acc  = push_i && !full_q;
        pop_acc   = pop_i && valid;
        ram_cnt   = wptr_q - rptr_q;
        free      = (occ - {1'b0, pop_acc}) < 2'd2;
        bypass    = push_acc && ram_cnt == '0 && !rd_pend && free;
        ram_we    = push_acc && !bypass && !clr_i;
        ram_re    = ram_cnt != '0 && free && !clr_i;
        load      = bypass || rd_pend;
        load_data = rd_pend ? ram_dout : din_i;
        wptr_d    = clr_i ? '0 : ram_we ? fifo_ptr_t'(wptr_q + 1'b1) : wptr_q;
        rptr_d    = clr_i ? '0 : ram_re ? fifo_ptr_t'(rptr_q + 1'b1) : rptr_q;
        count_d   = clr_i ? '0 : count_q + CW'(push_acc) - CW'(pop_acc);
        full_d    = count_d == CW'(DEPTH);
        afull_d   = count_d >= CW'(AFULL_LVL);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            afull_q <= afull_d;
        end
    end

    riscv_ram_1r1w #(
        .ABITS(ABITS), .DBITS(DBITS), .TECHNOLOGY(TECHNOLOGY)
    ) u_ram (
        .clk_i  (clk_i),
        .waddr_i(wptr_q.idx),
        .we_i   (ram_we),
        .be_i   ('1),
        .din_i  (din_i),
        .raddr_i(rptr_q.idx),
        .re_i   (ram_re),
        .dout_o (ram_dout)
    );

    riscv_fifo_outbuf #(.DBITS(DBITS)) u_outbuf (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (clr_i),
        .load_i     (load),
        .load_data_i(load_data),
        .issue_i    (ram_re),
        .pop_i      (pop_acc),
        .head_o     (dout_o),
        .valid_o    (valid),
        .rd_pend_o  (rd_pend),
        .occ_o      (occ)
    );

    assign full_o        = full_q;
    assign almost_full_o = afull_q;
    assign empty_o       = !valid;
    assign count_o       = count_q;
endmodule

// File: tb/tb_riscv_ram_fifo.sv
// tb_riscv_ram_fifo: queue-model scoreboard plus directed literal checks for riscv_ram_fifo.
module tb_riscv_ram_fifo;
    localparam int ABITS = 10;
    localparam int DBITS = 32;
    localparam int DEPTH = 1 << ABITS;
    localparam int AFULL = DEPTH - 4;

    logic             clk = 1'b0, rst_n = 1'b0, clr = 1'b0, push = 1'b0, pop = 1'b0;
    logic [DBITS-1:0] din = '0, dout;
    logic             full, afull, empty;
    logic [ABITS:0]   count;
    int               checks = 0, errors = 0;
    logic [DBITS-1:0] q[$];

    riscv_ram_fifo #(
        .ABITS(ABITS), .DBITS(DBITS), .TECHNOLOGY("GENERIC"), .AFULL_LVL(AFULL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr),
        .push_i       (push),
        .din_i        (din),
        .full_o       (full),
        .almost_full_o(afull),
        .pop_i        (pop),
        .dout_o       (dout),
        .empty_o      (empty),
        .count_o      (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of accepted words.
    always @(posedge clk or negedge rst_n) begin
        bit pa, pp;
        if (!rst_n || clr) q.delete();
        else begin
            pa = push && q.size() < DEPTH;
            pp = pop && q.size() > 0;
            if (pp) void'(q.pop_front());
            if (pa) q.push_back(din);
        end
    end

    always @(negedge clk)
        if (rst_n) begin
            check("m_count", count, q.size());
            check("m_empty", empty, q.size() == 0);
            check("m_full", full, q.size() == DEPTH);
            check("m_afull", afull, q.size() >= AFULL);
            if (q.size() > 0) check("m_dout", dout, q[0]);
        end

    task automatic cyc(input logic p, input logic [DBITS-1:0] d, input logic o, input logic c = 1'b0);
        push = p; din = d; pop = o; clr = c;
        @(negedge clk);
    endtask

    initial begin
        logic [DBITS-1:0] exp_w;
        #12 rst_n = 1'b1;
        @(negedge clk);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", afull, 0);
        check("rst_dout", dout, 0);

        cyc(1, 32'hA5A5_0001, 0);
        check("t1_empty", empty, 0);
        check("t1_dout", dout, 32'hA5A5_0001);
        check("t1_count", count, 1);
        cyc(0, 0, 0, 1);
        check("clr_count", count, 0);

        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, i, 0);
            if (i == AFULL - 2) check("t2_afull_below", afull, 0);
            if (i == AFULL - 1) check("t2_afull_at", afull, 1);
            if (i == DEPTH - 2) check("t2_not_full", full, 0);
        end
        check("t2_full", full, 1);
        check("t2_count_full", count, DEPTH);
        cyc(1, 32'hDEAD, 0);
        check("t4_push_full_count", count, DEPTH);
        check("t2_head0", dout, 0);
        cyc(1, 32'hBEEF, 1);
        check("t4_pushpop_full_count", count, DEPTH - 1);
        check("t4_pushpop_full_flag", full, 0);
        for (int i = 1; i < DEPTH; i++) begin
            check("t2_order", dout, i);
            cyc(0, 0, 1);
        end
        check("t2_drained", empty, 1);
        cyc(0, 0, 1);
        check("t4_pop_empty_count", count, 0);
        check("t4_pop_empty_flag", empty, 1);

        for (int i = 0; i < 4; i++) cyc(1, 100 + i, 0);
        exp_w = 100;
        for (int i = 0; i < 5000; i++) begin
            check("t3_nobubble", empty, 0);
            check("t3_order", dout, exp_w);
            exp_w++;
            cyc(1, 104 + i, 1);
        end
        check("t3_count", count, 4);
        repeat (4) cyc(0, 0, 1);
        check("t3_drained", empty, 1);

        cyc(1, 32'h11, 0);
        cyc(1, 32'h22, 0);
        cyc(1, 32'h33, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 0, 1);
        check("t5_count", count, 0);
        check("t5_empty", empty, 1);
        cyc(1, 32'h1234, 0);
        check("t5_first", dout, 32'h1234);
        cyc(0, 0, 1);
        repeat (3) cyc(0, 0, 0);
        check("t5_no_stale", empty, 1);

        for (int i = 0; i < 4; i++) cyc(1, 32'h200 + i, 0);
        for (int i = 0; i < 10; i++) cyc(1, 32'h300 + i, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        push = 1'b0; pop = 1'b0;
        #1;
        check("t6_count", count, 0);
        check("t6_empty", empty, 1);
        check("t6_full", full, 0);
        check("t6_afull", afull, 0);
        check("t6_dout", dout, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        repeat (3) cyc(0, 0, 0);
        check("t6_no_stale", empty, 1);
        cyc(1, 32'h55, 0);
        check("t6_after", dout, 32'h55);
        cyc(0, 0, 1);
        check("t6_final_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
